fetch_controller: RTL
=====================

Name: fetch_controller

Overview:
- Sequences the instruction memory for the pipelined CPU's IF stage.
- Drives the memory's `startin` load phase after reset, then produces the word-aligned fetch `address` each cycle.
- Registers the returned instruction and its PC into the IF/ID interface.
- Handles ID-stage stalls, EX-stage branch/jump redirects and a halt condition, so the top level needs no separate PC logic.

Parameters:
- ADDR_W, 32, width of PC and memory address.
- RESET_PC, 32'd0, first fetch address after the init phase.
- INIT_CYCLES, 2, number of cycles `imem_startin` stays high after reset (range 1..255).
- MEM_BYTES, 48, instruction memory size in bytes; the last valid word is at MEM_BYTES-4.
- HALT_INSTR, 32'hFFFF_FFFF, encoding that stops fetching.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_instruction  in  32  combinational read data from instruction memory for `imem_addr`.
- stall  in  1  ID hazard unit requests hold of PC and the IF/ID outputs.
- redirect  in  1  EX stage resolved a taken branch or jump.
- redirect_pc  in  ADDR_W  target address for `redirect`.
- imem_addr  out  ADDR_W  fetch address to instruction memory.
- imem_startin  out  1  load/init strobe to instruction memory.
- if_instr  out  32  registered fetched instruction.
- if_pc  out  ADDR_W  registered PC of `if_instr`.
- if_valid  out  1  `if_instr`/`if_pc` hold a real instruction (0 = bubble).
- halted  out  1  fetch stopped.
- fetch_count  out  32  number of instructions issued with `if_valid`=1 since reset.

Behaviour:
- Interface fixed: one clock `clk`; `reset` is synchronous and active-high.
- States: S_INIT, S_RUN, S_HALT (encoding 2'd0/1/2).
- Reset (synchronous, any state, including mid-operation):
  - state=S_INIT, pc=RESET_PC, init_cnt=0.
  - imem_startin=1, if_instr=0, if_pc=0, if_valid=0, halted=0, fetch_count=0.
- imem_addr is combinational from the pc register, with bits [1:0] forced to 0 in every state.
- S_INIT:
  - imem_startin=1; init_cnt increments each cycle.
  - When init_cnt==INIT_CYCLES-1: next state S_RUN; imem_startin drops to 0 in the first S_RUN cycle.
  - stall and redirect are ignored; if_valid stays 0.
- S_RUN, evaluated in priority order each cycle:
  1. Redirect: pc<=redirect_pc with [1:0] cleared; if_valid<=0 (flush the wrong-path word); if_instr/if_pc keep their old values. Redirect beats stall when both are asserted.
  2. Stall: pc, if_instr, if_pc and if_valid all hold.
  3. Normal fetch: if_instr<=imem_instruction, if_pc<=pc, if_valid<=1, fetch_count+=1, pc<=pc+4.
     - If imem_instruction==HALT_INSTR, or pc==MEM_BYTES-4: the word is still issued (if_valid<=1), then next state S_HALT and halted<=1 on the same edge. pc holds (no wrap past the end of memory).
  - Latency: the instruction at address A appears on if_instr one clock after imem_addr==A.
- S_HALT:
  - if_valid<=0 every cycle; pc and fetch_count hold; halted=1; stall is ignored.
  - redirect: pc<=redirect_pc, halted<=0, next state S_RUN. This covers a halt word that was fetched speculatively behind a taken branch.
- Arithmetic: pc+4 is ADDR_W-bit modulo, but the halt rule prevents pc ever exceeding MEM_BYTES-4 through increment.
- Redirect to an address >= MEM_BYTES: fetch proceeds; the memory returns its out-of-range value; the halt rule fires only on an exact match to MEM_BYTES-4.
- fetch_count wraps at 2^32.

Decomposition:
- Shared package `cpu_defs`: state encodings, HALT_INSTR, NOP encoding, ADDR_W.
- One natural sub-module, `pc_register`: holds pc and applies the load (redirect), hold (stall) and increment (+4) selection.
- The FSM, init counter and IF/ID registers stay in fetch_controller.

Test Plan:
1. Reset, INIT_CYCLES=2 -> imem_startin=1 for exactly 2 cycles, then 0; first if_valid=1 on the cycle after imem_addr=0, with if_pc=0; imem_addr steps 0,4,8,... one word per cycle.
2. stall high for 3 cycles while imem_addr=8 -> imem_addr stays 8 and if_pc stays 4 for 3 cycles; after release, if_pc=8 arrives on the next clock.
3. redirect=1 with redirect_pc=32'd22 while stall=1 -> next imem_addr=20, if_valid=0 for one cycle, then if_pc=20 with if_valid=1.
4. Memory returns 32'hFFFF_FFFF at address 12 -> if_pc=12 issued with if_valid=1, then halted=1, if_valid=0 and imem_addr frozen; fetch_count=4.
5. Sequential run to address 44 (MEM_BYTES=48) -> word 44 issued, then halted=1 with pc held at 44 (no fetch at 48); a subsequent redirect to 0 clears halted and fetching resumes from 0.
6. reset asserted mid-run at imem_addr=16 -> on the next edge imem_startin=1, if_valid=0, fetch_count=0, imem_addr=0, and the init phase repeats.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: fetch FSM state encoding and instruction constants.
package cpu_defs;

   localparam int unsigned CPU_ADDR_W     = 32;
   localparam logic [31:0] CPU_HALT_INSTR = 32'hFFFF_FFFF;
   localparam logic [31:0] CPU_NOP        = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_INIT = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/pc_register.sv
// Program counter with load (redirect), increment (+4) and implicit hold.
module pc_register #(
   parameter int unsigned       ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_load,
   input  logic [ADDR_W-1:0] i_load_pc,
   input  logic              i_inc,
   output logic [ADDR_W-1:0] o_pc
);

   logic [ADDR_W-1:0] r_pc;

   // Load wins over increment; neither asserted means hold.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc <= RESET_PC;
      end else if (i_load) begin
         r_pc <= {i_load_pc[ADDR_W-1:2], 2'b00};
      end else if (i_inc) begin
         r_pc <= r_pc + ADDR_W'(4);
      end
   end

   assign o_pc = r_pc;

endmodule

// File: rtl/fetch_controller.sv
// IF-stage sequencer: memory init strobe, PC stepping, IF/ID registers,
// stall/redirect handling and halt detection.
module fetch_controller
   import cpu_defs::*;
#(
   parameter int unsigned       ADDR_W      = CPU_ADDR_W,
   parameter logic [ADDR_W-1:0] RESET_PC    = '0,
   parameter int unsigned       INIT_CYCLES = 2,
   parameter int unsigned       MEM_BYTES   = 48,
   parameter logic [31:0]       HALT_INSTR  = CPU_HALT_INSTR
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       imem_instruction,
   input  logic              stall,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic [ADDR_W-1:0] imem_addr,
   output logic              imem_startin,
   output logic [31:0]       if_instr,
   output logic [ADDR_W-1:0] if_pc,
   output logic              if_valid,
   output logic              halted,
   output logic [31:0]       fetch_count
);

   fetch_state_e      r_state;
   fetch_state_e      w_state_next;
   logic [7:0]        r_init_cnt;
   logic [31:0]       r_if_instr;
   logic [ADDR_W-1:0] r_if_pc;
   logic              r_if_valid;
   logic              r_halted;
   logic [31:0]       r_fetch_count;

   logic [ADDR_W-1:0] w_pc;
   logic [ADDR_W-1:0] w_fetch_addr;
   logic              w_load;
   logic              w_inc;
   logic              w_issue;
   logic              w_stop;
   logic              w_end;

   pc_register #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_pc_register (
      .clk       (clk),
      .reset     (reset),
      .i_load    (w_load),
      .i_load_pc (redirect_pc),
      .i_inc     (w_inc),
      .o_pc      (w_pc)
   );

   assign w_fetch_addr = {w_pc[ADDR_W-1:2], 2'b00};
   assign w_end = (imem_instruction == HALT_INSTR) ||
                  (w_fetch_addr == ADDR_W'(MEM_BYTES - 4));

   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      w_inc        = 1'b0;
      w_issue      = 1'b0;
      w_stop       = 1'b0;
      unique case (r_state)
         S_INIT: begin
            if (r_init_cnt == 8'(INIT_CYCLES - 1)) w_state_next = S_RUN;
         end
         S_RUN: begin
            if (redirect) begin
               w_load = 1'b1;
            end else if (!stall) begin
               w_issue = 1'b1;
               // Last word is still issued; pc must not step past it.
               if (w_end) begin
                  w_stop       = 1'b1;
                  w_state_next = S_HALT;
               end else begin
                  w_inc = 1'b1;
               end
            end
         end
         S_HALT: begin
            if (redirect) begin
               w_load       = 1'b1;
               w_state_next = S_RUN;
            end
         end
         default: w_state_next = S_INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= S_INIT;
         r_init_cnt    <= '0;
         r_if_instr    <= '0;
         r_if_pc       <= '0;
         r_if_valid    <= 1'b0;
         r_halted      <= 1'b0;
         r_fetch_count <= '0;
      end else begin
         r_state <= w_state_next;
         if (r_state == S_INIT) r_init_cnt <= r_init_cnt + 8'd1;
         if (w_issue) begin
            r_if_instr    <= imem_instruction;
            r_if_pc       <= w_pc;
            r_if_valid    <= 1'b1;
            r_fetch_count <= r_fetch_count + 32'd1;
         end else if (w_load || r_state == S_HALT) begin
            r_if_valid <= 1'b0;
         end
         if (w_stop) begin
            r_halted <= 1'b1;
         end else if (r_state == S_HALT && redirect) begin
            r_halted <= 1'b0;
         end
      end
   end

   assign imem_addr    = w_fetch_addr;
   assign imem_startin = (r_state == S_INIT);
   assign if_instr     = r_if_instr;
   assign if_pc        = r_if_pc;
   assign if_valid     = r_if_valid;
   assign halted       = r_halted;
   assign fetch_count  = r_fetch_count;

endmodule
